// File: rtl/rr_flush_arbiter.sv
// Round-robin arbiter that feeds a two-entry spill stage, with a flush sequencer.
// Input acceptance happens only in IDLE, so a flush and a write can never hit the stage together.
module rr_flush_arbiter #(
    parameter int unsigned NumInp   = 4,
    parameter type         T        = logic,
    parameter int unsigned IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NumInp-1:0]   inp_valid_i,
    output logic [NumInp-1:0]   inp_ready_o,
    input  T     [NumInp-1:0]   inp_data_i,
    output logic                oup_valid_o,
    input  logic                oup_ready_i,
    output T                    oup_data_o,
    output logic [IdxWidth-1:0] oup_idx_o,
    input  logic                flush_req_i,
    output logic                flush_ack_o,
    output logic [1:0]          dropped_o,
    output logic                busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLOCK = 2'd1,
        ST_FLUSH = 2'd2,
        ST_ACK   = 2'd3
    } state_e;

    state_e state_reg, state_next;

    logic [IdxWidth-1:0] ptr_reg, ptr_next;
    logic [1:0]          dropped_reg, dropped_next;

    logic                a_full_reg, a_full_next;
    T                    a_data_reg, a_data_next;
    logic [IdxWidth-1:0] a_idx_reg, a_idx_next;
    logic                b_full_reg, b_full_next;
    T                    b_data_reg, b_data_next;
    logic [IdxWidth-1:0] b_idx_reg, b_idx_next;

    logic [NumInp-1:0]   ptr_mask;
    logic [NumInp-1:0]   masked_valid;
    logic [NumInp-1:0]   search_vec;
    logic [NumInp-1:0]   grant;
    logic [IdxWidth-1:0] grant_idx;
    logic                is_idle;
    logic                stage_ready;
    logic                accept;
    logic                flush_now;
    logic                a_drain;
    logic                b_fill;
    logic                b_drain;

    // ------------------------------------------------------------------
    // Arbitration: search from ptr upwards first, then wrap to index 0.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NumInp; gi++) begin : g_mask
            assign ptr_mask[gi] = (gi >= int'(ptr_reg));
        end
    endgenerate

    assign masked_valid = inp_valid_i & ptr_mask;
    assign search_vec   = (|masked_valid) ? masked_valid : inp_valid_i;
    // Isolate the lowest set bit of the search vector.
    assign grant        = search_vec & (~search_vec + NumInp'(1));

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NumInp; i++) begin
            if (grant[i]) begin
                grant_idx = IdxWidth'(i);
            end
        end
    end

    assign is_idle     = (state_reg == ST_IDLE);
    assign stage_ready = !(a_full_reg && b_full_reg);
    assign accept      = (|inp_valid_i) && stage_ready && is_idle;
    assign flush_now   = (state_reg == ST_FLUSH);

    generate
        for (genvar gi = 0; gi < NumInp; gi++) begin : g_ready
            assign inp_ready_o[gi] = grant[gi] & stage_ready & is_idle;
        end
    endgenerate

    always_comb begin
        ptr_next = ptr_reg;
        if (accept) begin
            if (grant_idx == IdxWidth'(NumInp - 1)) begin
                ptr_next = '0;
            end else begin
                ptr_next = grant_idx + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Spill stage: A takes new inputs, B holds A's word when output stalls.
    // ------------------------------------------------------------------
    assign a_drain = a_full_reg && !b_full_reg;
    assign b_fill  = a_drain && !oup_ready_i;
    assign b_drain = b_full_reg && oup_ready_i;

    always_comb begin
        a_full_next = a_full_reg;
        a_data_next = a_data_reg;
        a_idx_next  = a_idx_reg;
        b_full_next = b_full_reg;
        b_data_next = b_data_reg;
        b_idx_next  = b_idx_reg;

        if (flush_now) begin
            a_full_next = 1'b0;
            b_full_next = 1'b0;
        end else begin
            if (accept) begin
                a_full_next = 1'b1;
                a_data_next = inp_data_i[grant_idx];
                a_idx_next  = grant_idx;
            end else if (a_drain) begin
                a_full_next = 1'b0;
            end

            if (b_fill) begin
                b_full_next = 1'b1;
                b_data_next = a_data_reg;
                b_idx_next  = a_idx_reg;
            end else if (b_drain) begin
                b_full_next = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Flush sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        dropped_next = dropped_reg;
        case (state_reg)
            ST_IDLE: begin
                if (flush_req_i) begin
                    state_next = ST_BLOCK;
                end
            end
            ST_BLOCK: begin
                state_next = ST_FLUSH;
            end
            ST_FLUSH: begin
                state_next   = ST_ACK;
                dropped_next = {1'b0, a_full_reg} + {1'b0, b_full_reg};
            end
            ST_ACK: begin
                if (!flush_req_i) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg   <= ST_IDLE;
            ptr_reg     <= '0;
            dropped_reg <= '0;
            a_full_reg  <= 1'b0;
            a_data_reg  <= '0;
            a_idx_reg   <= '0;
            b_full_reg  <= 1'b0;
            b_data_reg  <= '0;
            b_idx_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            ptr_reg     <= ptr_next;
            dropped_reg <= dropped_next;
            a_full_reg  <= a_full_next;
            a_data_reg  <= a_data_next;
            a_idx_reg   <= a_idx_next;
            b_full_reg  <= b_full_next;
            b_data_reg  <= b_data_next;
            b_idx_reg   <= b_idx_next;
        end
    end

    // Outputs come straight from registers; valid is masked while the stage is being cleared.
    assign oup_valid_o = (a_full_reg || b_full_reg) && !flush_now;
    assign oup_data_o  = b_full_reg ? b_data_reg : a_data_reg;
    assign oup_idx_o   = b_full_reg ? b_idx_reg : a_idx_reg;
    assign flush_ack_o = (state_reg == ST_ACK);
    assign busy_o      = !is_idle;
    assign dropped_o   = dropped_reg;

`ifndef SYNTHESIS
    a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(inp_ready_o));
    a_no_accept_busy: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !((|inp_ready_o) && !is_idle));
`endif

endmodule

// File: tb/tb_rr_flush_arbiter.sv
// Bench for rr_flush_arbiter: vector table, hand-written flush/reset sequences and random
// traffic, all checked against a FIFO-based reference model of the arbiter.
module tb_rr_flush_arbiter;

    localparam int N = 4;
    typedef logic [7:0] data_t;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   inp_valid;
    logic [N-1:0]   inp_ready;
    data_t [N-1:0]  inp_data;
    logic           oup_valid;
    logic           oup_ready;
    data_t          oup_data;
    logic [1:0]     oup_idx;
    logic           flush_req;
    logic           flush_ack;
    logic [1:0]     dropped;
    logic           busy;

    int checks;
    int failures;
    int seq [N];

    rr_flush_arbiter #(
        .NumInp(N),
        .T     (data_t)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .inp_valid_i(inp_valid),
        .inp_ready_o(inp_ready),
        .inp_data_i (inp_data),
        .oup_valid_o(oup_valid),
        .oup_ready_i(oup_ready),
        .oup_data_o (oup_data),
        .oup_idx_o  (oup_idx),
        .flush_req_i(flush_req),
        .flush_ack_o(flush_ack),
        .dropped_o  (dropped),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Payload encodes the source in the top two bits and a per-source counter below.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            inp_data[i] = data_t'((i << 6) | (seq[i] & 63));
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        data_t data;
        int    idx;
    } ent_t;

    ent_t mq[$];          // stage contents, oldest first, at most two
    int   m_ptr;
    int   m_phase;        // 0 idle, 1 block, 2 flush, 3 ack
    int   m_dropped;

    task automatic model_reset();
        mq.delete();
        m_ptr     = 0;
        m_phase   = 0;
        m_dropped = 0;
    endtask

    function automatic int m_grant();
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (inp_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        int g;
        r = '0;
        g = m_grant();
        if (m_phase == 0 && mq.size() < 2 && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    function automatic logic m_valid();
        return (mq.size() > 0) && (m_phase != 2);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("model_inp_ready", 32'(inp_ready), 32'(m_ready()));
        check("model_oup_valid", 32'(oup_valid), 32'(m_valid()));
        if (m_valid()) begin
            check("model_oup_data", 32'(oup_data), 32'(mq[0].data));
            check("model_oup_idx", 32'(oup_idx), 32'(mq[0].idx));
        end
        check("model_flush_ack", 32'(flush_ack), 32'(m_phase == 3));
        check("model_busy", 32'(busy), 32'(m_phase != 0));
        check("model_dropped", 32'(dropped), 32'(m_dropped));
    endtask

    task automatic sample();
        @(negedge clk);
        compare_model();
        if (oup_valid && oup_ready)
            $display("t=%0t out idx=%0d data=%h", $time, oup_idx, oup_data);
    endtask

    task automatic advance();
        logic [N-1:0] r;
        int   g;
        int   old_phase;
        logic pop;
        @(posedge clk);
        r         = m_ready();
        g         = m_grant();
        pop       = m_valid() && oup_ready;
        old_phase = m_phase;
        case (m_phase)
            0: if (flush_req) m_phase = 1;
            1: m_phase = 2;
            2: begin
                m_dropped = mq.size();
                mq.delete();
                m_phase = 3;
            end
            default: if (!flush_req) m_phase = 0;
        endcase
        if (old_phase != 2) begin
            if (pop) void'(mq.pop_front());
            if (r != '0) begin
                mq.push_back('{inp_data[g], g});
                m_ptr = (g + 1) % N;
            end
        end
        #1;
        if (r != '0) seq[g]++;
    endtask

    task automatic drive(input logic [N-1:0] v, input logic r, input logic f);
        inp_valid = v;
        oup_ready = r;
        flush_req = f;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0] valid;
        logic         rdy;
        int           set_seq0;
        logic [N-1:0] exp_ready;
        logic         exp_valid;
        logic [1:0]   exp_idx;
        data_t        exp_data;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [N-1:0] v, input logic r, input int s, input logic [N-1:0] er,
                       input logic ev, input logic [1:0] ei, input data_t ed);
        tbl.push_back('{v, r, s, er, ev, ei, ed});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < N; i++) seq[i] = 0;

        // round robin, all valid, output always ready
        add(4'b1111, 1'b1, -1, 4'b0001, 1'b0, 2'd0, 8'h00);
        add(4'b1111, 1'b1, -1, 4'b0010, 1'b1, 2'd0, 8'h00);
        add(4'b1111, 1'b1, -1, 4'b0100, 1'b1, 2'd1, 8'h40);
        add(4'b1111, 1'b1, -1, 4'b1000, 1'b1, 2'd2, 8'h80);
        add(4'b1111, 1'b1, -1, 4'b0001, 1'b1, 2'd3, 8'hC0);
        add(4'b1111, 1'b1, -1, 4'b0010, 1'b1, 2'd0, 8'h01);
        // sparse: inputs 1 and 3 with ptr at 2
        add(4'b1010, 1'b1, -1, 4'b1000, 1'b1, 2'd1, 8'h41);
        add(4'b1010, 1'b1, -1, 4'b0010, 1'b1, 2'd3, 8'hC1);
        add(4'b1010, 1'b1, -1, 4'b1000, 1'b1, 2'd1, 8'h42);
        add(4'b0000, 1'b1, -1, 4'b0000, 1'b1, 2'd3, 8'hC2);
        add(4'b0000, 1'b1, -1, 4'b0000, 1'b0, 2'd0, 8'h00);
        // back-pressure: input 0 streams 0x0A, 0x0B, 0x0C
        add(4'b0001, 1'b0, 10, 4'b0001, 1'b0, 2'd0, 8'h00);
        add(4'b0001, 1'b0, -1, 4'b0001, 1'b1, 2'd0, 8'h0A);
        add(4'b0001, 1'b0, -1, 4'b0000, 1'b1, 2'd0, 8'h0A);
        add(4'b0001, 1'b0, -1, 4'b0000, 1'b1, 2'd0, 8'h0A);
        add(4'b0001, 1'b1, -1, 4'b0000, 1'b1, 2'd0, 8'h0A);
        add(4'b0001, 1'b1, -1, 4'b0001, 1'b1, 2'd0, 8'h0B);
        add(4'b0000, 1'b1, -1, 4'b0000, 1'b1, 2'd0, 8'h0C);
        add(4'b0000, 1'b0, -1, 4'b0000, 1'b0, 2'd0, 8'h00);

        // ---------------- reset ----------------
        rst_n = 1'b0;
        drive('0, 1'b0, 1'b0);
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_oup_valid", 32'(oup_valid), 0);
        check("reset_oup_data", 32'(oup_data), 0);
        check("reset_oup_idx", 32'(oup_idx), 0);
        check("reset_flush_ack", 32'(flush_ack), 0);
        check("reset_dropped", 32'(dropped), 0);
        check("reset_busy", 32'(busy), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ---------------- table ----------------
        for (int k = 0; k < tbl.size(); k++) begin
            if (tbl[k].set_seq0 >= 0) seq[0] = tbl[k].set_seq0;
            drive(tbl[k].valid, tbl[k].rdy, 1'b0);
            sample();
            $display("vec %0d: valid=%b rdy=%b -> ready=%b oup_valid=%b idx=%0d data=%h",
                     k, inp_valid, oup_ready, inp_ready, oup_valid, oup_idx, oup_data);
            check("vec_inp_ready", 32'(inp_ready), 32'(tbl[k].exp_ready));
            check("vec_oup_valid", 32'(oup_valid), 32'(tbl[k].exp_valid));
            if (tbl[k].exp_valid) begin
                check("vec_oup_idx", 32'(oup_idx), 32'(tbl[k].exp_idx));
                check("vec_oup_data", 32'(oup_data), 32'(tbl[k].exp_data));
            end
            advance();
        end

        // ---------------- flush during drain ----------------
        drive(4'b0010, 1'b1, 1'b1);
        sample();
        check("drain_ready_before", 32'(inp_ready), 32'h2);
        advance();
        sample();
        check("drain_block_busy", 32'(busy), 1);
        check("drain_block_ready", 32'(inp_ready), 0);
        check("drain_block_data", 32'(oup_data), 32'h43);
        check("drain_block_valid", 32'(oup_valid), 1);
        advance();
        sample();
        check("drain_flush_valid", 32'(oup_valid), 0);
        check("drain_flush_ack", 32'(flush_ack), 0);
        advance();
        sample();
        check("drain_ack", 32'(flush_ack), 1);
        check("drain_dropped", 32'(dropped), 0);
        advance();
        drive('0, 1'b1, 1'b0);
        sample();
        check("drain_ack_hold", 32'(flush_ack), 1);
        advance();
        drive(4'b1111, 1'b1, 1'b0);
        sample();
        $display("drain flush done: busy=%b ready=%b", busy, inp_ready);
        check("drain_idle_busy", 32'(busy), 0);
        check("drain_ptr_kept", 32'(inp_ready), 32'h4);
        advance();

        // ---------------- flush of a full stage ----------------
        drive(4'b1000, 1'b0, 1'b0);
        sample();
        check("full_fill_ready", 32'(inp_ready), 32'h8);
        advance();
        drive(4'b1000, 1'b0, 1'b1);
        sample();
        check("full_stage_ready", 32'(inp_ready), 0);
        advance();
        sample();
        check("full_block_busy", 32'(busy), 1);
        check("full_block_data", 32'(oup_data), 32'h81);
        advance();
        sample();
        check("full_flush_valid", 32'(oup_valid), 0);
        advance();
        sample();
        check("full_ack", 32'(flush_ack), 1);
        check("full_dropped", 32'(dropped), 2);
        check("full_ack_valid", 32'(oup_valid), 0);
        for (int k = 0; k < 2; k++) begin
            advance();
            sample();
            check("full_ack_held", 32'(flush_ack), 1);
        end
        advance();
        drive('0, 1'b1, 1'b0);
        sample();
        advance();
        drive(4'b1111, 1'b1, 1'b0);
        sample();
        $display("full flush done: busy=%b dropped=%0d ready=%b", busy, dropped, inp_ready);
        check("full_idle_busy", 32'(busy), 0);
        check("full_dropped_held", 32'(dropped), 2);
        check("full_ptr_kept", 32'(inp_ready), 32'h1);
        advance();

        // ---------------- asynchronous reset in FLUSH ----------------
        drive(4'b0010, 1'b0, 1'b0);
        sample();
        advance();
        drive('0, 1'b0, 1'b1);
        sample();
        advance();
        sample();
        advance();
        #2;
        check("rst_pre_busy", 32'(busy), 1);
        rst_n = 1'b0;
        drive('0, 1'b0, 1'b0);
        #1;
        check("rst_mid_valid", 32'(oup_valid), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_ack", 32'(flush_ack), 0);
        check("rst_mid_dropped", 32'(dropped), 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        advance();
        drive(4'b1111, 1'b1, 1'b0);
        sample();
        $display("after mid-flush reset: ready=%b", inp_ready);
        check("rst_first_grant", 32'(inp_ready), 32'h1);
        advance();

        // ---------------- random traffic ----------------
        for (int k = 0; k < 400; k++) begin
            logic f;
            f = flush_req;
            if ($urandom_range(0, 11) == 0) f = ~f;
            drive(N'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0), f);
            sample();
            advance();
        end
        drive('0, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            sample();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
